// File: rtl/elastic_rr_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output stage; each beat carries its source index.
// Optional ARB_BURST_EN: let the last winner keep the grant for up to MAX_BURST consecutive beats.
module elastic_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DW        = 32,
    parameter int SW        = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ*DW-1:0] t_data,
    input  logic [NUM_REQ-1:0]    t_valid,
    output logic [NUM_REQ-1:0]    t_ready,
    output logic [DW-1:0]         i0_data,
    output logic [SW-1:0]         i0_src,
    output logic                  i0_valid,
    input  logic                  i0_ready
);

    // Handshake: a transfer happens on a port when valid and ready are both high at posedge.
    localparam logic [SW-1:0] LAST_RST = SW'(NUM_REQ - 1);

    logic [DW-1:0]      r_data;
    logic [SW-1:0]      r_src;
    logic               r_valid;
    logic [SW-1:0]      r_last;

    logic               w_load;
    logic               w_accept;
    logic               w_found;
    logic [SW-1:0]      w_next;
    logic [SW-1:0]      w_start;
    logic [SW-1:0]      w_idx;
    logic [SW:0]        w_pos;
    logic [NUM_REQ-1:0] w_gnt;

    assign w_load   = ~r_valid | i0_ready;
    assign w_next   = (r_last == LAST_RST) ? '0 : r_last + SW'(1);

`ifdef ARB_BURST_EN
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [BW-1:0] r_bcnt;
    logic          w_keep;

    // A burst is only in progress once the current owner has had at least one beat.
    assign w_keep  = t_valid[r_last] && (r_bcnt != '0) && (r_bcnt < BW'(MAX_BURST));
    assign w_start = w_keep ? r_last : w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcnt <= '0;
        end else if (w_load) begin
            if (w_accept) begin
                if (w_idx == r_last) begin
                    if (r_bcnt < BW'(MAX_BURST)) begin
                        r_bcnt <= r_bcnt + BW'(1);
                    end
                end else begin
                    r_bcnt <= BW'(1);
                end
            end else begin
                r_bcnt <= '0;
            end
        end
    end
`else
    assign w_start = w_next;
`endif

    // Circular priority search beginning at w_start; the first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_pos   = '0;
        w_gnt   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_pos = {1'b0, w_start} + (SW + 1)'(i);
            if (w_pos >= (SW + 1)'(NUM_REQ)) begin
                w_pos = w_pos - (SW + 1)'(NUM_REQ);
            end
            if (!w_found && t_valid[w_pos[SW-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_pos[SW-1:0];
            end
        end
        w_gnt[w_idx] = w_found;
    end

    assign w_accept = w_load & w_found;
    assign t_ready  = (w_load && !rst) ? w_gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_src   <= '0;
            r_valid <= 1'b0;
            r_last  <= LAST_RST;
        end else if (w_load) begin
            if (w_accept) begin
                r_data  <= t_data[w_idx*DW +: DW];
                r_src   <= w_idx;
                r_valid <= 1'b1;
                r_last  <= w_idx;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign i0_data  = r_data;
    assign i0_src   = r_src;
    assign i0_valid = r_valid;

endmodule

// File: tb/tb_elastic_rr_arbiter.sv
// Self-checking bench for elastic_rr_arbiter: directed scenarios plus randomized traffic against a beat-level model.
module tb_elastic_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int MB = 2;

    logic            clk;
    logic            rst;
    logic [N*DW-1:0] t_data;
    logic [N-1:0]    t_valid;
    logic [N-1:0]    t_ready;
    logic [DW-1:0]   i0_data;
    logic [SW-1:0]   i0_src;
    logic            i0_valid;
    logic            i0_ready;

    int checks = 0;
    int errors = 0;

    // Reference model: the output beat, the last winner and the consecutive-beat count.
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    int            m_src   = 0;
    int            m_last  = N - 1;
    int            m_bcnt  = 0;

    elastic_rr_arbiter #(.NUM_REQ(N), .DW(DW), .SW(SW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .t_data(t_data), .t_valid(t_valid), .t_ready(t_ready),
        .i0_data(i0_data), .i0_src(i0_src), .i0_valid(i0_valid), .i0_ready(i0_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int m_grant();
        int start;
        if (rst || !(!m_valid || i0_ready)) return -1;
        start = (m_last + 1) % N;
`ifdef ARB_BURST_EN
        if (m_bcnt > 0 && m_bcnt < MB && t_valid[m_last]) start = m_last;
`endif
        for (int off = 0; off < N; off++) begin
            if (t_valid[(start + off) % N]) return (start + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int g;
        g = m_grant();
        return (g >= 0) ? N'(1 << g) : '0;
    endfunction

    task automatic cycle();
        int g;
        logic ld;
        g  = m_grant();
        ld = !m_valid || i0_ready;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_src = 0; m_last = N - 1; m_bcnt = 0;
        end else if (ld) begin
            if (g >= 0) begin
                if (g == m_last) begin
                    if (m_bcnt < MB) m_bcnt++;
                end else begin
                    m_bcnt = 1;
                end
                m_data  = t_data[g*DW +: DW];
                m_src   = g;
                m_valid = 1'b1;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
                m_bcnt  = 0;
            end
        end
        #1;
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) t_data[k*DW +: DW] = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1; t_valid = '0; i0_ready = 1'b1;
        #1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; t_valid = 4'hF; i0_ready = 1'b1;
        rand_data();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (t_ready !== 4'b0000) begin errors++; $display("FAIL reset_t_ready: got %b expected 0000", t_ready); end
            cycle();
            checks++;
            if (i0_valid !== 1'b0 || i0_data !== '0 || i0_src !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got valid=%b data=%h src=%0d expected 0/0/0", i0_valid, i0_data, i0_src);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (t_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected 0001", t_ready); end
        cycle();
        checks++;
        if (i0_valid !== 1'b1 || i0_src !== 2'd0 || i0_data !== t_data[0 +: DW]) begin
            errors++;
            $display("FAIL reset_first_beat: got valid=%b src=%0d data=%h expected 1/0/%h", i0_valid, i0_src, i0_data, t_data[0 +: DW]);
        end
    endtask

    task automatic test_lone();
        logic [DW-1:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        t_valid = 4'b0100; i0_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            t_data[2*DW +: DW] = vals[i];
            #1;
            checks++;
            if (t_ready !== 4'b0100) begin errors++; $display("FAIL lone_t_ready: got %b expected 0100", t_ready); end
            cycle();
            checks++;
            if (i0_valid !== 1'b1 || i0_src !== 2'd2 || i0_data !== vals[i]) begin
                errors++;
                $display("FAIL lone_beat%0d: got valid=%b src=%0d data=%h expected 1/2/%h", i, i0_valid, i0_src, i0_data, vals[i]);
            end
        end
    endtask

    task automatic test_all_valid();
        int exp_src [6];
        logic [DW-1:0] exp_d;
`ifdef ARB_BURST_EN
        exp_src = '{0, 0, 1, 1, 2, 2};
`else
        exp_src = '{0, 1, 2, 3, 0, 1};
`endif
        do_reset();
        t_valid = 4'hF; i0_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            exp_d = t_data[exp_src[i]*DW +: DW];
            #1;
            checks++;
            if (t_ready !== N'(1 << exp_src[i])) begin
                errors++; $display("FAIL all_valid_t_ready%0d: got %b expected grant %0d", i, t_ready, exp_src[i]);
            end
            cycle();
            checks++;
            if (i0_valid !== 1'b1 || i0_src !== SW'(exp_src[i]) || i0_data !== exp_d) begin
                errors++;
                $display("FAIL all_valid_beat%0d: got src=%0d data=%h expected %0d/%h", i, i0_src, i0_data, exp_src[i], exp_d);
            end
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] held;
        int eg;
`ifdef ARB_BURST_EN
        eg = 1;
`else
        eg = 2;
`endif
        do_reset();
        t_valid = 4'b0010; i0_ready = 1'b1;
        rand_data();
        held = t_data[1*DW +: DW];
        #1;
        cycle();
        i0_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            t_valid = 4'hF;
            rand_data();
            #1;
            checks++;
            if (t_ready !== 4'b0000) begin errors++; $display("FAIL stall_t_ready%0d: got %b expected 0000", i, t_ready); end
            cycle();
            checks++;
            if (i0_valid !== 1'b1 || i0_src !== 2'd1 || i0_data !== held) begin
                errors++;
                $display("FAIL stall_hold%0d: got valid=%b src=%0d data=%h expected 1/1/%h", i, i0_valid, i0_src, i0_data, held);
            end
        end
        i0_ready = 1'b1;
        #1;
        checks++;
        if (t_ready !== N'(1 << eg)) begin errors++; $display("FAIL stall_release_grant: got %b expected grant %0d", t_ready, eg); end
        cycle();
        checks++;
        if (i0_src !== SW'(eg) || i0_valid !== 1'b1) begin
            errors++; $display("FAIL stall_release_src: got %0d expected %0d", i0_src, eg);
        end
    endtask

    task automatic test_wrap();
        int exp_src [3];
`ifdef ARB_BURST_EN
        exp_src = '{1, 1, 3};
`else
        exp_src = '{1, 3, 1};
`endif
        do_reset();
        t_valid = 4'b1010; i0_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            #1;
            cycle();
            checks++;
            if (i0_src !== SW'(exp_src[i]) || i0_valid !== 1'b1) begin
                errors++; $display("FAIL wrap_src%0d: got %0d expected %0d", i, i0_src, exp_src[i]);
            end
        end
    endtask

`ifdef ARB_BURST_EN
    task automatic test_burst_drop();
        logic [N-1:0] tv [4];
        int exp_src [4];
        tv = '{4'hF, 4'hF, 4'hF, 4'b1101};
        exp_src = '{0, 0, 1, 2};
        do_reset();
        i0_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            t_valid = tv[i];
            rand_data();
            #1;
            cycle();
            checks++;
            if (i0_src !== SW'(exp_src[i])) begin
                errors++; $display("FAIL burst_drop_src%0d: got %0d expected %0d", i, i0_src, exp_src[i]);
            end
        end
    endtask
`endif

    task automatic test_back_to_back_random();
        logic [N-1:0] er;
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            t_valid  = ($urandom_range(0, 3) == 0) ? 4'hF : N'($urandom_range(0, 15));
            i0_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            #1;
            er = m_ready();
            checks++;
            if (t_ready !== er) begin errors++; $display("FAIL random_t_ready%0d: got %b expected %b", i, t_ready, er); end
            cycle();
            checks++;
            if (i0_valid !== m_valid || i0_src !== SW'(m_src) || i0_data !== m_data) begin
                errors++;
                $display("FAIL random_out%0d: got valid=%b src=%0d data=%h expected %b/%0d/%h",
                         i, i0_valid, i0_src, i0_data, m_valid, m_src, m_data);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; t_valid = '0; t_data = '0; i0_ready = 1'b1;
        test_reset();
        test_lone();
        test_all_valid();
        test_stall();
        test_wrap();
`ifdef ARB_BURST_EN
        test_burst_drop();
`endif
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
